// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU control path: sequencer states,
// jump-target selects and the fixed instruction width.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;

    // HALT is all-ones so every decoder control output decodes inactive.
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC1 = 2'b01,
        ST_EXEC2 = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        JS_REG    = 2'b00,
        JS_DIRECT = 2'b01,
        JS_RET    = 2'b10,
        JS_HOLD   = 2'b11
    } jump_sel_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter: jump-target mux, load-over-count priority and stop gating.
// The PC only moves while the sequencer is active (not halted).
module pc_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              active,
    input  logic              stop,
    input  logic              pc_sload,
    input  logic              pc_cnt_en,
    input  logic [1:0]        jump_sel,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [ADDR_W-1:0] ret_addr,
    input  logic [11:0]       direct_field,
    output logic [ADDR_W-1:0] pc
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] target;
    jump_sel_e         js;

    assign js = jump_sel_e'(jump_sel);
    assign pc = pc_q;

    // Jump-target select; the direct field is zero-extended or truncated to ADDR_W.
    always_comb begin
        target = pc_q;
        unique case (js)
            JS_REG:    target = reg_target;
            JS_DIRECT: target = ADDR_W'(direct_field);
            JS_RET:    target = ret_addr;
            JS_HOLD:   target = pc_q;
            default:   target = pc_q;
        endcase
    end

    // Next PC: stop freezes, load beats count, count wraps modulo 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (active && !stop) begin
            if (pc_sload) begin
                pc_d = target;
            end else if (pc_cnt_en) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // PC register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Upstream control stage: FETCH/EXEC1/EXEC2/HALT sequencing, instruction
// register with EXEC1 bypass of the 1-cycle-latency instruction RAM, and a
// retired-instruction counter. The PC lives in pc_unit.
module fetch_sequencer #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               sm_extra,
    input  logic               stop,
    input  logic               pc_sload,
    input  logic               pc_cnt_en,
    input  logic [1:0]         jump_sel,
    input  logic [ADDR_W-1:0]  reg_target,
    input  logic [ADDR_W-1:0]  ret_addr,
    input  logic [INSTR_W-1:0] instr_rdata,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [1:0]         state,
    output logic               halted,
    output logic [15:0]        retired
);
    import cpu_pkg::*;

    state_e             state_q;
    state_e             state_d;
    logic               halted_q;
    logic               halted_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic [15:0]        retired_q;
    logic [15:0]        retired_d;
    logic               retire;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clock        (clock),
        .reset_n      (reset_n),
        .active       (state_q != ST_HALT),
        .stop         (stop),
        .pc_sload     (pc_sload),
        .pc_cnt_en    (pc_cnt_en),
        .jump_sel     (jump_sel),
        .reg_target   (reg_target),
        .ret_addr     (ret_addr),
        .direct_field (instruction[11:0]),
        .pc           (pc)
    );

    assign instr_addr = pc;
    assign state      = state_q;
    assign halted     = halted_q;
    assign retired    = retired_q;

    // In EXEC1 the RAM word is fresh and not yet in IR, so bypass it.
    always_comb begin
        instruction = ir_q;
        if (state_q == ST_EXEC1) begin
            instruction = instr_rdata;
        end
    end

    // Next state; stop wins over sm_extra and is ignored while halted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HALT:  if (run) state_d = ST_FETCH;
            ST_FETCH: state_d = stop ? ST_HALT : ST_EXEC1;
            ST_EXEC1: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else if (sm_extra) begin
                    state_d = ST_EXEC2;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC2: state_d = stop ? ST_HALT : ST_FETCH;
            default:  state_d = ST_HALT;
        endcase
    end

    // IR load, retire detection and registered halted flag.
    always_comb begin
        ir_d      = ir_q;
        retire    = 1'b0;
        retired_d = retired_q;
        halted_d  = (state_d == ST_HALT);
        if (state_q == ST_EXEC1) begin
            ir_d = instr_rdata;
        end
        if ((state_q == ST_EXEC1 || state_q == ST_EXEC2) && state_d == ST_FETCH) begin
            retire = 1'b1;
        end
        if (retire) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Sequencer state, IR and retired counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_HALT;
            halted_q  <= 1'b1;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with hand-computed
// expectations, plus hand-written async-reset and halt sequences.
module tb_fetch_sequencer;

    typedef struct {
        logic        run;
        logic        sm;
        logic        stp;
        logic        sload;
        logic        cnt;
        logic [1:0]  js;
        logic [15:0] reg_t;
        logic [15:0] ret;
        logic [15:0] rdata;
        logic [1:0]  e_state;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_retired;
        logic        e_halted;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run, sm_extra, stop, pc_sload, pc_cnt_en;
    logic [1:0]  jump_sel;
    logic [15:0] reg_target, ret_addr, instr_rdata;
    logic [15:0] instr_addr, pc, instruction, retired;
    logic [1:0]  state;
    logic        halted;

    int checks = 0;
    int errors = 0;

    vec_t vecs [24];

    always #5 clock = ~clock;

    fetch_sequencer #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .sm_extra    (sm_extra),
        .stop        (stop),
        .pc_sload    (pc_sload),
        .pc_cnt_en   (pc_cnt_en),
        .jump_sel    (jump_sel),
        .reg_target  (reg_target),
        .ret_addr    (ret_addr),
        .instr_rdata (instr_rdata),
        .instr_addr  (instr_addr),
        .pc          (pc),
        .instruction (instruction),
        .state       (state),
        .halted      (halted),
        .retired     (retired)
    );

    function automatic vec_t mk(
        input logic run_i, sm_i, stp_i, sload_i, cnt_i,
        input logic [1:0] js_i,
        input logic [15:0] reg_i, ret_i, rdata_i,
        input logic [1:0] st_e,
        input logic [15:0] pc_e, instr_e, retired_e,
        input logic halted_e);
        vec_t v;
        v.run = run_i; v.sm = sm_i; v.stp = stp_i; v.sload = sload_i; v.cnt = cnt_i;
        v.js = js_i; v.reg_t = reg_i; v.ret = ret_i; v.rdata = rdata_i;
        v.e_state = st_e; v.e_pc = pc_e; v.e_instr = instr_e;
        v.e_retired = retired_e; v.e_halted = halted_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [15:0] p,
                             input logic [15:0] ins, input logic [15:0] ret, input logic h);
        check({tag, ".state"},       32'(state),       32'(st));
        check({tag, ".pc"},          32'(pc),          32'(p));
        check({tag, ".instr_addr"},  32'(instr_addr),  32'(p));
        check({tag, ".instruction"}, 32'(instruction), 32'(ins));
        check({tag, ".retired"},     32'(retired),     32'(ret));
        check({tag, ".halted"},      32'(halted),      32'(h));
    endtask

    task automatic apply(input vec_t v);
        run = v.run; sm_extra = v.sm; stop = v.stp; pc_sload = v.sload; pc_cnt_en = v.cnt;
        jump_sel = v.js; reg_target = v.reg_t; ret_addr = v.ret; instr_rdata = v.rdata;
    endtask

    task automatic idle_inputs();
        run = 0; sm_extra = 0; stop = 0; pc_sload = 0; pc_cnt_en = 0;
        jump_sel = 2'b00; reg_target = '0; ret_addr = '0; instr_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //           run sm st ld cn js reg       ret       rdata     | st pc        instr     ret  h
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1111, 0, 16'h0000, 16'h0000, 16'd0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h1111, 1, 16'h0001, 16'h1111, 16'd0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1111, 0, 16'h0001, 16'h1111, 16'd1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h2222, 1, 16'h0002, 16'h2222, 16'd1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h2222, 0, 16'h0002, 16'h2222, 16'd2, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h8123, 1, 16'h0003, 16'h8123, 16'd2, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h8123, 2, 16'h0003, 16'h8123, 16'd2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 16'h0003, 16'h8123, 16'd3, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hC0A5, 1, 16'h0004, 16'hC0A5, 16'd3, 0);
        vecs[9]  = mk(0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 16'hC0A5, 0, 16'h00A5, 16'hC0A5, 16'd4, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h5000, 1, 16'h00A6, 16'h5000, 16'd4, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 2, 16'h0000, 16'h1234, 16'h5000, 0, 16'h1234, 16'h5000, 16'd5, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h6000, 1, 16'h1235, 16'h6000, 16'd5, 0);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 16'h0F0F, 16'h0000, 16'h6000, 0, 16'h0F0F, 16'h6000, 16'd6, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h7000, 1, 16'h0F10, 16'h7000, 16'd6, 0);
        vecs[15] = mk(0, 0, 0, 1, 1, 3, 16'h0000, 16'h0000, 16'h7000, 0, 16'h0F10, 16'h7000, 16'd7, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h9000, 1, 16'h0F11, 16'h9000, 16'd7, 0);
        vecs[17] = mk(0, 1, 1, 0, 1, 0, 16'h0000, 16'h0000, 16'h9000, 3, 16'h0F11, 16'h9000, 16'd7, 1);
        vecs[18] = mk(0, 0, 1, 1, 1, 0, 16'hAAAA, 16'h0000, 16'h1357, 3, 16'h0F11, 16'h9000, 16'd7, 1);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1357, 0, 16'h0F11, 16'h9000, 16'd7, 0);
        vecs[20] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hA000, 1, 16'h0F12, 16'hA000, 16'd7, 0);
        vecs[21] = mk(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 16'hA000, 0, 16'hFFFF, 16'hA000, 16'd8, 0);
        vecs[22] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hB000, 1, 16'h0000, 16'hB000, 16'd8, 0);
        vecs[23] = mk(0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hB000, 2, 16'h0001, 16'hB000, 16'd8, 0);

        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset", 2'b11, 16'h0000, 16'h0000, 16'd0, 1'b1);

        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check_all("idle_halt", 2'b11, 16'h0000, 16'h0000, 16'd0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            apply(vecs[i]);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_pc,
                      vecs[i].e_instr, vecs[i].e_retired, vecs[i].e_halted);
        end

        // Asynchronous reset in the middle of an EXEC2 cycle.
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 2'b11, 16'h0000, 16'h0000, 16'd0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        // stop in FETCH halts with PC frozen.
        run = 1;
        tick();
        check_all("run2", 2'b00, 16'h0000, 16'h0000, 16'd0, 1'b0);
        run = 0; stop = 1; pc_cnt_en = 1;
        tick();
        check_all("fetch_stop", 2'b11, 16'h0000, 16'h0000, 16'd0, 1'b1);

        // stop in EXEC2 halts without retiring.
        idle_inputs();
        run = 1;
        tick();
        check_all("run3", 2'b00, 16'h0000, 16'h0000, 16'd0, 1'b0);
        run = 0; pc_cnt_en = 1; instr_rdata = 16'h8001;
        tick();
        check_all("e1_b", 2'b01, 16'h0001, 16'h8001, 16'd0, 1'b0);
        pc_cnt_en = 0; sm_extra = 1;
        tick();
        check_all("e2_b", 2'b10, 16'h0001, 16'h8001, 16'd0, 1'b0);
        sm_extra = 0; stop = 1; pc_cnt_en = 1; instr_rdata = 16'h4444;
        tick();
        check_all("e2_stop", 2'b11, 16'h0001, 16'h8001, 16'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
